// File: rtl/sdram_dev_resp_pkg.sv
// Shared SDRAM command-bus definitions: command codes, mode register fields,
// address geometry and small decode helpers used by both ends of the link.
`ifndef SDRAM_DEV_RESP_PKG_MACROS
`define SDRAM_DEV_RESP_PKG_MACROS
// Flat memory address {bank, row, col}: bank[23:22], row[21:9], col[8:0]
`define SDRAM_MEM_ADDR(ba, row, col) {(ba), (row), (col)}
`endif

package sdram_dev_resp_pkg;

    // Address geometry
    localparam int BANK_W    = 2;
    localparam int ROW_W     = 13;
    localparam int COL_W     = 9;
    localparam int MEM_AW    = BANK_W + ROW_W + COL_W;
    localparam int NUM_BANKS = 4;
    localparam int TMR_W     = 4;   // timing parameters up to 16 clocks

    // Mode register field positions and the auto-precharge / all-banks bit
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int ADDR_AP_BIT = 10;

    // Raw command words {cke, csn, rasn, casn, wen}
    localparam logic [4:0] CODE_NOP = 5'b1_0111;
    localparam logic [4:0] CODE_ACT = 5'b1_0011;
    localparam logic [4:0] CODE_RD  = 5'b1_0101;
    localparam logic [4:0] CODE_WR  = 5'b1_0100;
    localparam logic [4:0] CODE_PRE = 5'b1_0010;
    localparam logic [4:0] CODE_REF = 5'b1_0001;
    localparam logic [4:0] CODE_LMR = 5'b1_0000;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_LMR, CMD_IGN
    } sdram_cmd_e;

    // Running burst: remaining beats after the current one, next column
    typedef struct packed {
        logic              wr;
        logic              ap;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [2:0]        left;
    } burst_t;

    function automatic sdram_cmd_e decode_cmd(input logic cke, input logic csn,
                                              input logic rasn, input logic casn,
                                              input logic wen);
        sdram_cmd_e c;
        c = CMD_IGN;
        if (!cke || csn) begin
            c = CMD_NOP;
        end else begin
            case ({cke, csn, rasn, casn, wen})
                CODE_NOP: c = CMD_NOP;
                CODE_ACT: c = CMD_ACT;
                CODE_RD:  c = CMD_RD;
                CODE_WR:  c = CMD_WR;
                CODE_PRE: c = CMD_PRE;
                CODE_REF: c = CMD_REF;
                CODE_LMR: c = CMD_LMR;
                default:  c = CMD_IGN;
            endcase
        end
        return c;
    endfunction

    // Sequential burst order: only the bits under mask advance, mod BL
    function automatic logic [COL_W-1:0] burst_wrap(input logic [COL_W-1:0] col,
                                                    input logic [COL_W-1:0] mask);
        logic [COL_W-1:0] inc;
        inc = col + 1'b1;
        return (col & ~mask) | (inc & mask);
    endfunction

endpackage

// File: rtl/sdram_bank_trk.sv
// One SDRAM bank: open/idle state, active row, and tRCD / tRP countdowns.
module sdram_bank_trk
    import sdram_dev_resp_pkg::*;
#(
    parameter int TRCD = 2,
    parameter int TRP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act,
    input  logic             pre,
    input  logic [ROW_W-1:0] row_in,
    output logic             is_open,
    output logic [ROW_W-1:0] row,
    output logic             rcd_ok,
    output logic             rp_ok
);
    localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(TRCD - 1);
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(TRP - 1);

    logic             open_reg;
    logic [ROW_W-1:0] row_reg;
    logic [TMR_W-1:0] rcd_reg;
    logic [TMR_W-1:0] rp_reg;

    // Bank state: precharge wins over activate, activate latches the row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_reg <= 1'b0;
            row_reg  <= '0;
        end else if (pre) begin
            open_reg <= 1'b0;
        end else if (act) begin
            open_reg <= 1'b1;
            row_reg  <= row_in;
        end
    end

    // tRCD countdown, reloaded on activate, saturating at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcd_reg <= '0;
        end else if (act && !pre) begin
            rcd_reg <= RCD_LOAD;
        end else if (rcd_reg != '0) begin
            rcd_reg <= rcd_reg - 1'b1;
        end
    end

    // tRP countdown, reloaded whenever the bank is closed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_reg <= '0;
        end else if (pre) begin
            rp_reg <= RP_LOAD;
        end else if (rp_reg != '0) begin
            rp_reg <= rp_reg - 1'b1;
        end
    end

    assign is_open = open_reg;
    assign row     = row_reg;
    assign rcd_ok  = (rcd_reg == '0);
    assign rp_ok   = (rp_reg == '0);

endmodule

// File: rtl/sdram_dev_resp.sv
// SDRAM device-side responder: decodes the command bus, tracks mode and banks,
// expands bursts into single-beat memory accesses and flags timing violations.
module sdram_dev_resp
    import sdram_dev_resp_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TRCD = 2,
    parameter int TRP  = 2,
    parameter int TRFC = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_cke,
    input  logic              sdram_csn,
    input  logic              sdram_rasn,
    input  logic              sdram_casn,
    input  logic              sdram_wen,
    input  logic [1:0]        sdram_ba,
    input  logic [12:0]       sdram_addr,
    input  logic [DW-1:0]     sdram_dq_i,
    output logic [DW-1:0]     sdram_dq_o,
    output logic              sdram_dq_oe,
    output logic [23:0]       mem_addr,
    output logic              mem_wr_en,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_rd_en,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mode_ok,
    output logic [4:0]        err_flags
);
    localparam logic [TMR_W-1:0] RFC_LOAD = TMR_W'(TRFC - 1);

    sdram_cmd_e        cmd;
    logic              cmd_valid, cmd_rw, rw_ok;
    logic [NUM_BANKS-1:0] bank_open, bank_rcd_ok, bank_rp_ok, bank_act, bank_pre;
    logic [ROW_W-1:0]  bank_row [NUM_BANKS];
    logic              sel_open, sel_rcd_ok, sel_rp_ok;
    logic [ROW_W-1:0]  sel_row;

    logic [2:0]        cl_reg;
    logic [1:0]        bl_code_reg;
    logic              mode_ok_reg;
    logic [2:0]        lmr_cl, lmr_bl;
    logic              lmr_cl_ok, lmr_bl_ok;
    logic [3:0]        bl_len;
    logic [2:0]        bl_last;
    logic [COL_W-1:0]  bl_mask;

    logic [TMR_W-1:0]  rfc_reg;
    logic [4:0]        err_reg, err_next;

    burst_t            burst_reg, burst_next;
    logic              beat_valid, beat_wr, ap_close;
    logic [BANK_W-1:0] ap_bank;
    logic [MEM_AW-1:0] beat_addr;
    logic              rd_dly_valid_reg;
    logic [MEM_AW-1:0] rd_dly_addr_reg;
    logic              wr_fire, rd_fire, rd_pend_reg;
    logic [MEM_AW-1:0] rd_addr;

    assign cmd       = decode_cmd(sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen);
    assign cmd_valid = (cmd != CMD_NOP) && (cmd != CMD_IGN);
    assign cmd_rw    = (cmd == CMD_RD) || (cmd == CMD_WR);

    assign sel_open   = bank_open[sdram_ba];
    assign sel_rcd_ok = bank_rcd_ok[sdram_ba];
    assign sel_rp_ok  = bank_rp_ok[sdram_ba];
    assign sel_row    = bank_row[sdram_ba];
    assign rw_ok      = cmd_rw && sel_open;

    assign lmr_cl    = sdram_addr[MODE_CL_MSB:MODE_CL_LSB];
    assign lmr_bl    = sdram_addr[MODE_BL_MSB:MODE_BL_LSB];
    assign lmr_cl_ok = (lmr_cl == 3'd2) || (lmr_cl == 3'd3);
    assign lmr_bl_ok = !lmr_bl[2];
    assign bl_len    = 4'd1 << bl_code_reg;
    assign bl_last   = bl_len[2:0] - 3'd1;      // BL=8 wraps to 7
    assign bl_mask   = {{(COL_W-3){1'b0}}, bl_last};

    // One tracker per bank; activate only reaches an idle bank
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign bank_act[gi] = (cmd == CMD_ACT) && (sdram_ba == BANK_W'(gi)) && !bank_open[gi];
            assign bank_pre[gi] = ((cmd == CMD_PRE) &&
                                   (sdram_addr[ADDR_AP_BIT] || sdram_ba == BANK_W'(gi))) ||
                                  (ap_close && ap_bank == BANK_W'(gi));
            sdram_bank_trk #(.TRCD(TRCD), .TRP(TRP)) u_trk (
                .clk     (clk),
                .rst_n   (rst_n),
                .act     (bank_act[gi]),
                .pre     (bank_pre[gi]),
                .row_in  (sdram_addr),
                .is_open (bank_open[gi]),
                .row     (bank_row[gi]),
                .rcd_ok  (bank_rcd_ok[gi]),
                .rp_ok   (bank_rp_ok[gi])
            );
        end
    endgenerate

    // Burst engine: a new access truncates the running burst; an auto-precharge
    // of a truncated burst is dropped, otherwise it closes on the last beat
    always_comb begin
        burst_next = burst_reg;
        beat_valid = 1'b0;
        beat_wr    = 1'b0;
        beat_addr  = '0;
        ap_close   = 1'b0;
        ap_bank    = burst_reg.bank;
        if (rw_ok) begin
            beat_valid      = 1'b1;
            beat_wr         = (cmd == CMD_WR);
            beat_addr       = `SDRAM_MEM_ADDR(sdram_ba, sel_row, sdram_addr[COL_W-1:0]);
            burst_next.wr   = (cmd == CMD_WR);
            burst_next.ap   = sdram_addr[ADDR_AP_BIT];
            burst_next.bank = sdram_ba;
            burst_next.row  = sel_row;
            burst_next.col  = burst_wrap(sdram_addr[COL_W-1:0], bl_mask);
            burst_next.left = bl_last;
            if (bl_last == 3'd0 && sdram_addr[ADDR_AP_BIT]) begin
                ap_close = 1'b1;
                ap_bank  = sdram_ba;
            end
        end else if (burst_reg.left != 3'd0) begin
            beat_valid      = 1'b1;
            beat_wr         = burst_reg.wr;
            beat_addr       = `SDRAM_MEM_ADDR(burst_reg.bank, burst_reg.row, burst_reg.col);
            burst_next.col  = burst_wrap(burst_reg.col, bl_mask);
            burst_next.left = burst_reg.left - 3'd1;
            ap_close        = (burst_reg.left == 3'd1) && burst_reg.ap;
        end
    end

    // Burst state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) burst_reg <= '0;
        else        burst_reg <= burst_next;
    end

    // CL=3 issues read beats one clock after the burst engine produces them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dly_valid_reg <= 1'b0;
            rd_dly_addr_reg  <= '0;
        end else begin
            rd_dly_valid_reg <= beat_valid && !beat_wr;
            rd_dly_addr_reg  <= beat_addr;
        end
    end

    assign wr_fire = beat_valid && beat_wr;
    assign rd_fire = (cl_reg == 3'd2) ? (beat_valid && !beat_wr) : rd_dly_valid_reg;
    assign rd_addr = (cl_reg == 3'd2) ? beat_addr : rd_dly_addr_reg;

    // Memory port: one registered beat per clock; a write beat displaces a delayed read beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wr_en <= wr_fire;
            mem_rd_en <= rd_fire && !wr_fire;
            if (wr_fire) begin
                mem_addr  <= beat_addr;
                mem_wdata <= sdram_dq_i;
            end else if (rd_fire) begin
                mem_addr <= rd_addr;
            end
        end
    end

    // Read return: mem_rdata is valid the clock after mem_rd_en, then registered onto dq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_reg <= 1'b0;
            sdram_dq_oe <= 1'b0;
            sdram_dq_o  <= '0;
        end else begin
            rd_pend_reg <= mem_rd_en;
            sdram_dq_oe <= rd_pend_reg;
            sdram_dq_o  <= rd_pend_reg ? mem_rdata : '0;
        end
    end

    // Mode register: reserved CL or BL codes leave that field unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cl_reg      <= 3'd3;
            bl_code_reg <= 2'd3;
            mode_ok_reg <= 1'b0;
        end else if (cmd == CMD_LMR) begin
            mode_ok_reg <= 1'b1;
            if (lmr_cl_ok) cl_reg      <= lmr_cl;
            if (lmr_bl_ok) bl_code_reg <= lmr_bl[1:0];
        end
    end

    // Refresh recovery countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rfc_reg <= '0;
        else if (cmd == CMD_REF)   rfc_reg <= RFC_LOAD;
        else if (rfc_reg != '0)    rfc_reg <= rfc_reg - 1'b1;
    end

    // Protocol checks, accumulated as sticky flags {init, bank, trcd, trp, trfc}
    always_comb begin
        err_next = err_reg;
        if (((cmd == CMD_ACT) || cmd_rw) && !mode_ok_reg)           err_next[4] = 1'b1;
        if ((cmd == CMD_LMR) && !(lmr_cl_ok && lmr_bl_ok))          err_next[4] = 1'b1;
        if ((cmd == CMD_ACT) && sel_open)                           err_next[3] = 1'b1;
        if (cmd_rw && !sel_open)                                    err_next[3] = 1'b1;
        if ((cmd == CMD_REF) && (bank_open != '0))                  err_next[3] = 1'b1;
        if (rw_ok && !sel_rcd_ok)                                   err_next[2] = 1'b1;
        if ((cmd == CMD_ACT) && !sel_open && !sel_rp_ok)            err_next[1] = 1'b1;
        if (cmd_valid && (rfc_reg != '0))                           err_next[0] = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_reg <= '0;
        else        err_reg <= err_next;
    end

    assign err_flags = err_reg;
    assign mode_ok   = mode_ok_reg;

endmodule

// File: tb/tb_sdram_dev_resp.sv
// Directed bench for sdram_dev_resp: a vector table for the LMR/ACTIVE/WRITE/READ
// loopback plus hand sequences for tRCD, auto-precharge/tRP, tRFC, bank and reset cases.
module tb_sdram_dev_resp;

    localparam logic [4:0] C_NOP = 5'b1_0111;
    localparam logic [4:0] C_ACT = 5'b1_0011;
    localparam logic [4:0] C_RD  = 5'b1_0101;
    localparam logic [4:0] C_WR  = 5'b1_0100;
    localparam logic [4:0] C_PRE = 5'b1_0010;
    localparam logic [4:0] C_REF = 5'b1_0001;
    localparam logic [4:0] C_LMR = 5'b1_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_i;
    logic [15:0] sdram_dq_o;
    logic        sdram_dq_oe;
    logic [23:0] mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        mode_ok;
    logic [4:0]  err_flags;

    sdram_dev_resp #(.DW(16), .TRCD(2), .TRP(2), .TRFC(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sdram_cke   (sdram_cke),
        .sdram_csn   (sdram_csn),
        .sdram_rasn  (sdram_rasn),
        .sdram_casn  (sdram_casn),
        .sdram_wen   (sdram_wen),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .sdram_dq_i  (sdram_dq_i),
        .sdram_dq_o  (sdram_dq_o),
        .sdram_dq_oe (sdram_dq_oe),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wdata   (mem_wdata),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .mode_ok     (mode_ok),
        .err_flags   (err_flags)
    );

    always #5 clk = ~clk;

    // Flat memory: 1K words on the low address bits, plus a bench preload port
    logic [15:0] mem_arr [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_addr[9:0]] <= mem_wdata;
        if (pl_en)     mem_arr[pl_addr] <= pl_data;
        if (mem_rd_en) mem_rdata <= mem_arr[mem_addr[9:0]];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          oe_cnt   = 0;
    logic [15:0] rd_q [$];
    logic [4:0]  exp_err  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one command, advance one edge, sample 1 time unit after it
    task automatic step(input logic [4:0] c, input logic [1:0] ba, input logic [12:0] a,
                        input logic [15:0] d);
        {sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = c;
        sdram_ba   = ba;
        sdram_addr = a;
        sdram_dq_i = d;
        @(posedge clk);
        #1;
        if (sdram_dq_oe) begin
            oe_cnt++;
            rd_q.push_back(sdram_dq_o);
        end
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) step(C_NOP, 2'd0, 13'd0, 16'd0);
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [15:0] dq;
        logic        wr;
        logic        rd;
        logic [23:0] maddr;
        logic [15:0] wdata;
        logic        oe;
        logic [15:0] rdq;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // CL=3 BL=2 setup, write burst wrapping at col 0x1FF, then read it back
        vecs[0]  = '{C_LMR, 2'd0, 13'h0031, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[1]  = '{C_ACT, 2'd1, 13'h0005, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[2]  = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[3]  = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[4]  = '{C_WR,  2'd1, 13'h01FF, 16'hA5A5, 1, 0, 24'h400BFF, 16'hA5A5, 0, 16'h0};
        vecs[5]  = '{C_NOP, 2'd0, 13'h0000, 16'h5B5B, 1, 0, 24'h400BFE, 16'h5B5B, 0, 16'h0};
        vecs[6]  = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[7]  = '{C_RD,  2'd1, 13'h01FF, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};
        vecs[8]  = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 1, 24'h400BFF, 16'h0,    0, 16'h0};
        vecs[9]  = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 1, 24'h400BFE, 16'h0,    0, 16'h0};
        vecs[10] = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    1, 16'hA5A5};
        vecs[11] = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    1, 16'h5B5B};
        vecs[12] = '{C_NOP, 2'd0, 13'h0000, 16'h0000, 0, 0, 24'h0,      16'h0,    0, 16'h0};

        // Reset state
        rst_n = 1'b0;
        {sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = 5'b0_1111;
        sdram_ba = '0; sdram_addr = '0; sdram_dq_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dq_oe", sdram_dq_oe, 0);
        check("reset dq_o", sdram_dq_o, 0);
        check("reset mem_wr_en", mem_wr_en, 0);
        check("reset mem_rd_en", mem_rd_en, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mode_ok", mode_ok, 0);
        check("reset err_flags", err_flags, 0);
        $display("reset: checked idle outputs");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        preload(10'h210, 16'h1111);
        preload(10'h211, 16'h2222);

        // Table-driven loopback
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dq);
            $display("vec %0d: cmd=%b ba=%0d addr=%h wr=%b rd=%b maddr=%h oe=%b dq=%h err=%b",
                     i, vecs[i].cmd, vecs[i].ba, vecs[i].addr, mem_wr_en, mem_rd_en,
                     mem_addr, sdram_dq_oe, sdram_dq_o, err_flags);
            check($sformatf("vec%0d mem_wr_en", i), mem_wr_en, vecs[i].wr);
            check($sformatf("vec%0d mem_rd_en", i), mem_rd_en, vecs[i].rd);
            check($sformatf("vec%0d dq_oe", i), sdram_dq_oe, vecs[i].oe);
            check($sformatf("vec%0d err_flags", i), err_flags, 5'b0);
            if (vecs[i].wr || vecs[i].rd)
                check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].maddr);
            if (vecs[i].wr)
                check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
            if (vecs[i].oe)
                check($sformatf("vec%0d dq_o", i), sdram_dq_o, vecs[i].rdq);
        end
        check("mode_ok after LMR", mode_ok, 1);

        // tRCD violation: READ on the edge after ACTIVE still returns data
        step(C_ACT, 2'd2, 13'd7, 16'd0);
        oe_cnt = 0; rd_q.delete();
        step(C_RD, 2'd2, 13'h010, 16'd0);
        exp_err = 5'b00100;
        check("trcd err_flags", err_flags, exp_err);
        nops(2);
        check("trcd oe before CL", sdram_dq_oe, 0);
        nops(4);
        check("trcd beat count", oe_cnt, 2);
        if (rd_q.size() == 2) begin
            check("trcd data0", rd_q[0], 16'h1111);
            check("trcd data1", rd_q[1], 16'h2222);
        end else begin
            check("trcd data queue size", rd_q.size(), 2);
        end
        $display("seq trcd: beats=%0d err=%b", oe_cnt, err_flags);

        // BL=8 read with auto-precharge; ACTIVE one edge after the last beat hits tRP
        step(C_LMR, 2'd0, 13'h0033, 16'd0);
        oe_cnt = 0; rd_q.delete();
        step(C_RD, 2'd2, 13'h0410, 16'd0);
        nops(7);
        check("ap no early error", err_flags, exp_err);
        step(C_ACT, 2'd2, 13'd7, 16'd0);
        exp_err = 5'b00110;
        check("ap trp err_flags", err_flags, exp_err);
        nops(4);
        check("ap bl8 beat count", oe_cnt, 8);
        if (rd_q.size() >= 2) begin
            check("ap data0", rd_q[0], 16'h1111);
            check("ap data1", rd_q[1], 16'h2222);
        end
        step(C_PRE, 2'd2, 13'd0, 16'd0);
        nops(1);
        step(C_ACT, 2'd2, 13'd7, 16'd0);
        check("act after trp", err_flags, exp_err);
        $display("seq autoprecharge: beats=%0d err=%b", oe_cnt, err_flags);

        // Refresh then early ACTIVE; then READ to an idle bank
        step(C_PRE, 2'd0, 13'h0400, 16'd0);
        nops(2);
        step(C_REF, 2'd0, 13'd0, 16'd0);
        check("aref all idle", err_flags, exp_err);
        nops(2);
        step(C_ACT, 2'd0, 13'd3, 16'd0);
        exp_err = 5'b00111;
        check("trfc err_flags", err_flags, exp_err);
        nops(5);
        oe_cnt = 0;
        step(C_RD, 2'd3, 13'h000, 16'd0);
        exp_err = 5'b01111;
        check("idle read err_flags", err_flags, exp_err);
        nops(6);
        check("idle read no dq_oe", oe_cnt, 0);
        $display("seq refresh/idle: err=%b", err_flags);

        // Reset in the middle of a read burst
        step(C_RD, 2'd0, 13'h000, 16'd0);
        nops(4);
        check("burst oe before reset", sdram_dq_oe, 1);
        check("burst rd_en before reset", mem_rd_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset dq_oe", sdram_dq_oe, 0);
        check("async reset mem_rd_en", mem_rd_en, 0);
        check("async reset mode_ok", mode_ok, 0);
        check("async reset err_flags", err_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(C_ACT, 2'd0, 13'd3, 16'd0);
        check("act before LMR err_init", err_flags, 5'b10000);
        check("mode_ok after reset", mode_ok, 0);
        $display("seq reset: err=%b mode_ok=%b", err_flags, mode_ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
